calendar_date_counter: RTL and testbench
========================================

Name: calendar_date_counter

Overview:
- Sequential calendar core for the century clock. Advances day/month/year (year 00-99 within the century) on each day tick.
- Generates the month and leap-year information that the days-in-month display path consumes.
- Supports validated software/switch date loading.
- Outputs BCD digits ready for the giaima7thanh 7-segment decoders.

Parameters:
- RESET_DAY, 1, day value loaded on reset (1-31)
- RESET_MONTH, 1, month value loaded on reset (1-12)
- RESET_YEAR, 0, year-in-century loaded on reset (0-99)

Ports:
- clk  input  1  system clock; one clock domain, all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- day_tick  input  1  single-cycle pulse; advance date by one day
- set_en  input  1  single-cycle pulse; load set_day/set_month/set_year
- set_day  input  5  binary day to load (1-31)
- set_month  input  4  binary month to load (1-12)
- set_year  input  7  binary year-in-century to load (0-99)
- day_bcd  output  8  [7:4] tens, [3:0] units of current day
- month_bcd  output  8  [7:4] tens, [3:0] units of current month
- year_bcd  output  8  [7:4] tens, [3:0] units of current year
- leap  output  1  1 when current year % 4 == 0 (year 00 counts as leap)
- century_wrap  output  1  one-cycle pulse on the 31/12/99 -> 01/01/00 rollover
- set_err  output  1  one-cycle pulse when a load is rejected

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset, asserted at any time including mid-operation:
  - Date forced immediately to RESET_DAY/RESET_MONTH/RESET_YEAR.
  - century_wrap = 0, set_err = 0.
  - Reset-time BCD outputs therefore read 01/01/00, with leap = 1.
- State:
  - Binary registers day[4:0], month[3:0], year[6:0].
  - Registered BCD shadow copies, updated in the same edge as the binary registers, so outputs show the new date one cycle after the tick/set is sampled. No further latency.
- Days-in-month rule:
  - Months 1,3,5,7,8,10,12 -> 31.
  - Months 4,6,9,11 -> 30.
  - Month 2 -> 29 if leap, else 28.
- Tick (day_tick=1, set_en=0):
  - day < dim: day+1.
  - day == dim: day=1, then month+1; if month == 12, month=1 and then year+1.
  - year == 99 rolling over: year=0 and century_wrap=1 for exactly that cycle.
- Load (set_en=1):
  - Accepted only if 1 <= set_month <= 12, 1 <= set_day <= dim(set_month, set_year%4==0), and set_year <= 99.
  - Accepted: date replaced next edge.
  - Rejected: date unchanged, set_err=1 for one cycle.
- Simultaneous set_en and day_tick: set wins and the tick is discarded. This holds even if the load is rejected.
- day_tick held high for N cycles advances N days, one per cycle. No edge detection is done inside the block.
- State is always legal: there is no path into day 0, month 0/13+, or a day beyond dim.
- Arithmetic:
  - Increments are compared against the binary dim.
  - The BCD shadow increments units and carries into tens at 9 -> 0, so no binary-to-BCD divider is needed. Loads convert via a small lookup/shift-add.
- leap is combinational from year_bcd: units even-tens/0,4,8 or odd-tens/2,6.

Decomposition:
- Package calendar_pkg holds:
  - month constants MON_JAN..MON_DEC
  - DIM_31/DIM_30/DIM_FEB_LEAP/DIM_FEB_NORM
  - YEAR_MAX=99
- Sub-module days_in_month: month[3:0] + leap in, dim[4:0] out. It is purely combinational.
  - Used twice: once for the current date, once for the load validation.

Test Plan:
- Reset, then release -> day_bcd=8'h01, month_bcd=8'h01, year_bcd=8'h00, leap=1. Assert rst mid-sequence -> outputs return to 01/01/00 without waiting for clk.
- Load 31/01/23, one tick -> 01/02/23. Load 30/04/23, one tick -> 01/05/23.
- Load 28/02/23, tick -> 01/03/23. Load 28/02/24, tick -> 29/02/24 with leap=1; tick again -> 01/03/24.
- Load 31/12/99, tick -> 01/01/00 and century_wrap high for exactly one cycle, leap=1.
- Load 31/04/23 or 29/02/23 or month 13 -> set_err one-cycle pulse, date unchanged.
- set_en (15/06/10) and day_tick asserted in the same cycle -> 15/06/10, not 16/06/10. Hold day_tick 40 cycles from 01/01/05 -> 10/02/05.

Source files
------------

// File: rtl/calendar_pkg.sv
// Shared constants and helpers for the century calendar core.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package calendar_pkg;

   localparam logic [3:0] MON_JAN = 4'd1;
   localparam logic [3:0] MON_FEB = 4'd2;
   localparam logic [3:0] MON_MAR = 4'd3;
   localparam logic [3:0] MON_APR = 4'd4;
   localparam logic [3:0] MON_MAY = 4'd5;
   localparam logic [3:0] MON_JUN = 4'd6;
   localparam logic [3:0] MON_JUL = 4'd7;
   localparam logic [3:0] MON_AUG = 4'd8;
   localparam logic [3:0] MON_SEP = 4'd9;
   localparam logic [3:0] MON_OCT = 4'd10;
   localparam logic [3:0] MON_NOV = 4'd11;
   localparam logic [3:0] MON_DEC = 4'd12;

   localparam logic [4:0] DIM_31       = 5'd31;
   localparam logic [4:0] DIM_30       = 5'd30;
   localparam logic [4:0] DIM_FEB_LEAP = 5'd29;
   localparam logic [4:0] DIM_FEB_NORM = 5'd28;

   localparam logic [6:0] YEAR_MAX = 7'd99;

   // Shift-add-3 conversion; only ever fed values 0..99, so two digits suffice.
   function automatic logic [7:0] bin_to_bcd(input logic [6:0] bin);
      logic [14:0] s;
      s = {8'd0, bin};
      for (int i = 0; i < 7; i++) begin
         if (s[10:7] >= 4'd5) s[10:7] = s[10:7] + 4'd3;
         if (s[14:11] >= 4'd5) s[14:11] = s[14:11] + 4'd3;
         s = s << 1;
      end
      return s[14:7];
   endfunction

   // Two-digit BCD increment: units wrap 9 -> 0 and carry into tens.
   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
      else                return {v[7:4], v[3:0] + 4'd1};
   endfunction

   // Divisible by 4 from BCD digits: even tens need units 0/4/8, odd tens need 2/6.
   function automatic logic bcd_is_leap(input logic [7:0] v);
      if (!v[4]) return (v[3:0] == 4'd0) || (v[3:0] == 4'd4) || (v[3:0] == 4'd8);
      else       return (v[3:0] == 4'd2) || (v[3:0] == 4'd6);
   endfunction

endpackage

// File: rtl/days_in_month.sv
// Days-in-month lookup from month number and leap flag.
// Latency: purely combinational, zero cycles.
// Backpressure: none.
// Ports: month (1-12), leap (1 = February has 29 days), dim (28..31).
module days_in_month
   import calendar_pkg::*;
(
   input  logic [3:0] month,
   input  logic       leap,
   output logic [4:0] dim
);

   always_comb begin
      dim = DIM_31;
      case (month)
         MON_FEB:                            dim = leap ? DIM_FEB_LEAP : DIM_FEB_NORM;
         MON_APR, MON_JUN, MON_SEP, MON_NOV: dim = DIM_30;
         default:                            dim = DIM_31;
      endcase
   end

endmodule

// File: rtl/calendar_date_counter.sv
// Day/month/year-in-century counter with validated load and BCD outputs.
// Latency: new date visible on the outputs one cycle after day_tick/set_en is sampled.
// Backpressure: none; every tick and load is acted on in the cycle it is sampled.
// Ports: clk, rst (async, active-high); day_tick advances one day; set_en loads
//   set_day/set_month/set_year if legal, otherwise pulses set_err; outputs are
//   two-digit BCD day/month/year, leap flag and a one-cycle century_wrap pulse.
module calendar_date_counter
   import calendar_pkg::*;
#(
   parameter int RESET_DAY   = 1,
   parameter int RESET_MONTH = 1,
   parameter int RESET_YEAR  = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       day_tick,
   input  logic       set_en,
   input  logic [4:0] set_day,
   input  logic [3:0] set_month,
   input  logic [6:0] set_year,
   output logic [7:0] day_bcd,
   output logic [7:0] month_bcd,
   output logic [7:0] year_bcd,
   output logic       leap,
   output logic       century_wrap,
   output logic       set_err
);

   logic [4:0] day;
   logic [3:0] month;
   logic [6:0] year;

   logic [4:0] dim_cur;
   logic [4:0] dim_set;
   logic       set_leap;
   logic       set_ok;

   assign leap     = bcd_is_leap(year_bcd);
   assign set_leap = (set_year[1:0] == 2'b00);

   days_in_month u_dim_cur (
      .month (month),
      .leap  (leap),
      .dim   (dim_cur)
   );

   days_in_month u_dim_set (
      .month (set_month),
      .leap  (set_leap),
      .dim   (dim_set)
   );

   assign set_ok = (set_month >= MON_JAN) && (set_month <= MON_DEC) &&
                   (set_year <= YEAR_MAX) &&
                   (set_day != 5'd0) && (set_day <= dim_set);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         day          <= 5'(RESET_DAY);
         month        <= 4'(RESET_MONTH);
         year         <= 7'(RESET_YEAR);
         day_bcd      <= bin_to_bcd(7'(RESET_DAY));
         month_bcd    <= bin_to_bcd(7'(RESET_MONTH));
         year_bcd     <= bin_to_bcd(7'(RESET_YEAR));
         century_wrap <= 1'b0;
         set_err      <= 1'b0;
      end else begin
         century_wrap <= 1'b0;
         set_err      <= 1'b0;
         // A load always takes priority; a tick in the same cycle is dropped
         // even when the load itself is rejected.
         if (set_en) begin
            if (set_ok) begin
               day       <= set_day;
               month     <= set_month;
               year      <= set_year;
               day_bcd   <= bin_to_bcd({2'b00, set_day});
               month_bcd <= bin_to_bcd({3'b000, set_month});
               year_bcd  <= bin_to_bcd(set_year);
            end else begin
               set_err <= 1'b1;
            end
         end else if (day_tick) begin
            if (day < dim_cur) begin
               day     <= day + 5'd1;
               day_bcd <= bcd_inc(day_bcd);
            end else begin
               day     <= 5'd1;
               day_bcd <= 8'h01;
               if (month >= MON_DEC) begin
                  month     <= MON_JAN;
                  month_bcd <= 8'h01;
                  if (year >= YEAR_MAX) begin
                     year         <= 7'd0;
                     year_bcd     <= 8'h00;
                     century_wrap <= 1'b1;
                  end else begin
                     year     <= year + 7'd1;
                     year_bcd <= bcd_inc(year_bcd);
                  end
               end else begin
                  month     <= month + 4'd1;
                  month_bcd <= bcd_inc(month_bcd);
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_calendar_date_counter.sv
// Scoreboard bench for calendar_date_counter: driver pushes expected dates from
// a plain-arithmetic calendar model, monitor compares on each falling edge.
module tb_calendar_date_counter;

   logic       clk = 1'b0;
   logic       rst;
   logic       day_tick;
   logic       set_en;
   logic [4:0] set_day;
   logic [3:0] set_month;
   logic [6:0] set_year;
   logic [7:0] day_bcd;
   logic [7:0] month_bcd;
   logic [7:0] year_bcd;
   logic       leap;
   logic       century_wrap;
   logic       set_err;

   always #5 clk = ~clk;

   calendar_date_counter dut (
      .clk          (clk),
      .rst          (rst),
      .day_tick     (day_tick),
      .set_en       (set_en),
      .set_day      (set_day),
      .set_month    (set_month),
      .set_year     (set_year),
      .day_bcd      (day_bcd),
      .month_bcd    (month_bcd),
      .year_bcd     (year_bcd),
      .leap         (leap),
      .century_wrap (century_wrap),
      .set_err      (set_err)
   );

   typedef struct {
      int         cyc;
      logic [7:0] d, m, y;
      logic       lp, wr, er;
   } exp_t;

   exp_t q[$];
   exp_t me;
   int   cyc   = 0;
   int   tests = 0;
   int   fails = 0;

   // Reference calendar state, plain integers.
   int md = 1, mm = 1, my = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] to_bcd(input int v);
      return 8'(((v / 10) * 16) + (v % 10));
   endfunction

   function automatic int dim_f(input int m, input int y);
      if (m == 2) return (y % 4 == 0) ? 29 : 28;
      if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
      return 31;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // One stimulus cycle: drive inputs after the edge, update the model,
   // and queue what the outputs must show after the following edge.
   task automatic step(input bit tick, input bit set, input int sd, input int sm, input int sy);
      exp_t e;
      bit wr = 0, er = 0;
      @(posedge clk);
      #1;
      day_tick  = tick;
      set_en    = set;
      set_day   = 5'(sd);
      set_month = 4'(sm);
      set_year  = 7'(sy);
      if (set) begin
         if (sm >= 1 && sm <= 12 && sy <= 99 && sd >= 1 && sd <= dim_f(sm, sy)) begin
            md = sd; mm = sm; my = sy;
         end else begin
            er = 1;
         end
      end else if (tick) begin
         md++;
         if (md > dim_f(mm, my)) begin
            md = 1;
            mm++;
            if (mm > 12) begin
               mm = 1;
               my++;
               if (my > 99) begin
                  my = 0;
                  wr = 1;
               end
            end
         end
      end
      e.cyc = cyc + 1;
      e.d   = to_bcd(md);
      e.m   = to_bcd(mm);
      e.y   = to_bcd(my);
      e.lp  = (my % 4 == 0);
      e.wr  = wr;
      e.er  = er;
      q.push_back(e);
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0);
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() > 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("drain", 32'(q.size()), 32'd0);
   endtask

   // Monitor: compare every queued expectation on the falling edge it targets.
   always @(negedge clk) begin
      if (!rst) begin
         while (q.size() > 0 && q[0].cyc <= cyc) begin
            me = q.pop_front();
            check("date", {8'd0, day_bcd, month_bcd, year_bcd}, {8'd0, me.d, me.m, me.y});
            check("flags", {29'd0, leap, century_wrap, set_err}, {29'd0, me.lp, me.wr, me.er});
         end
      end
   end

   initial begin
      rst       = 1'b1;
      day_tick  = 1'b0;
      set_en    = 1'b0;
      set_day   = '0;
      set_month = '0;
      set_year  = '0;
      #3;
      check("reset_date", {8'd0, day_bcd, month_bcd, year_bcd}, 32'h00010100);
      check("reset_flags", {29'd0, leap, century_wrap, set_err}, 32'd4);
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle();

      // Month-end and year-end rollovers.
      step(0, 1, 31, 1, 23);  step(1, 0, 0, 0, 0);
      step(0, 1, 30, 4, 23);  step(1, 0, 0, 0, 0);
      step(0, 1, 28, 2, 23);  step(1, 0, 0, 0, 0);
      step(0, 1, 28, 2, 24);  step(1, 0, 0, 0, 0);  step(1, 0, 0, 0, 0);
      step(0, 1, 31, 12, 99); step(1, 0, 0, 0, 0);  idle();

      // Rejected loads leave the date untouched.
      step(0, 1, 31, 4, 23);
      step(0, 1, 29, 2, 23);
      step(0, 1, 15, 13, 23);
      step(0, 1, 0, 5, 23);
      step(0, 1, 10, 5, 100);
      idle();

      // Load beats a simultaneous tick, also when the load is rejected.
      step(1, 1, 15, 6, 10);  idle();
      step(1, 1, 31, 6, 10);  idle();

      // Asynchronous reset in the middle of operation.
      drain();
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_date", {8'd0, day_bcd, month_bcd, year_bcd}, 32'h00010100);
      check("async_rst_flags", {29'd0, leap, century_wrap, set_err}, 32'd4);
      md = 1; mm = 1; my = 0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle();

      // Held tick: 40 consecutive days from 01/01/05.
      step(0, 1, 1, 1, 5);
      for (int i = 0; i < 40; i++) step(1, 0, 0, 0, 0);
      idle();

      // Randomised mix of ticks, legal and illegal loads.
      for (int i = 0; i < 600; i++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r < 2) begin
            if ($urandom_range(0, 1) == 1)
               step($urandom_range(0, 1), 1, $urandom_range(1, 31), $urandom_range(1, 12), $urandom_range(0, 99));
            else
               step($urandom_range(0, 1), 1, $urandom_range(0, 31), $urandom_range(0, 15), $urandom_range(0, 127));
         end else if (r < 3) begin
            // Jump near a year end to exercise wraps often.
            step(0, 1, $urandom_range(25, 31), 12, $urandom_range(95, 99));
         end else begin
            step(r < 9, 0, 0, 0, 0);
         end
      end
      idle();
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
